// File: rtl/ram_io_responder.sv
// ---------------------------------------------------------------------------
// ram_io_responder
//
// Purpose:
//   Responder end of the byte-wide memory bus. It owns the unified
//   instruction/data RAM and a small memory-mapped I/O window:
//     0x30000 write : push byte into the TX (console output) FIFO
//     0x30000 read  : pop byte from the RX (console input) FIFO, 0 if empty
//     0x30004 write : set the sticky halt flag
//     0x30004 read  : status {6'b0, rx_nonempty, io_buffer_full}
//   Every bus cycle has one-cycle read latency through a registered ram_data.
//
// Ports:
//   clk            - single clock, posedge
//   rst            - asynchronous active-low reset
//   rdy            - global enable; low freezes RAM, FIFOs, ram_data, io_halt
//   mem_ram_addr   - byte address (only bits [17:0] are decoded)
//   mem_ram_data   - write byte
//   mem_ram_wr     - 1 = write, 0 = read
//   ram_data       - registered read byte
//   io_buffer_full - TX FIFO has at most one free slot
//   tx_valid/tx_data/tx_ready - TX FIFO head handshake towards the console
//   rx_valid/rx_data          - console input byte, pushed into the RX FIFO
//   io_halt        - sticky program-end flag
//
// Configuration:
//   RAM_IO_LOOPBACK_EN - when defined, TX drains one byte per cycle straight
//   into the RX FIFO, tx_valid is forced low and rx_valid/rx_data are ignored.
// ---------------------------------------------------------------------------

// Byte FIFO used for both console directions. Callers qualify push/pop with
// the global enable; the FIFO itself guards against overflow and underflow.
module ram_io_fifo #(
  parameter int DEPTH_LOG = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_head,
  output logic [DEPTH_LOG:0] o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [7:0]           r_buf [DEPTH];
  logic [DEPTH_LOG-1:0] r_wrPtr;
  logic [DEPTH_LOG-1:0] r_rdPtr;
  logic [DEPTH_LOG:0]   r_count;
  logic                 w_popOk;
  logic                 w_pushOk;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_popOk  = i_pop && (r_count != '0);
  assign w_pushOk = i_push && ((r_count != FULL_COUNT) || w_popOk);

  assign o_head  = r_buf[r_rdPtr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_buf[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

module ram_io_responder #(
  parameter int ADDR_WIDTH   = 17,
  parameter int TX_DEPTH_LOG = 3,
  parameter int RX_DEPTH_LOG = 3,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic [XLEN-1:0] mem_ram_addr,
  input  logic [7:0]      mem_ram_data,
  input  logic            mem_ram_wr,
  output logic [7:0]      ram_data,
  output logic            io_buffer_full,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            io_halt
);

  localparam logic [TX_DEPTH_LOG:0] TX_FULL_MARK =
    (TX_DEPTH_LOG + 1)'((1 << TX_DEPTH_LOG) - 1);

  logic [7:0] r_mem [2**ADDR_WIDTH];
  logic [7:0] r_ramQ;
  logic [7:0] r_ioData;
  logic       r_selRam;
  logic       r_halt;

  logic [ADDR_WIDTH-1:0] w_ramAddr;
  logic                  w_isIo;
  logic                  w_ioDataPort;
  logic                  w_ioStatusPort;
  logic                  w_busRead;
  logic                  w_busWrite;
  logic [7:0]            w_ioReadData;

  logic                    w_txPush;
  logic                    w_txPop;
  logic                    w_txHasData;
  logic [7:0]              w_txHead;
  logic [TX_DEPTH_LOG:0]   w_txCount;

  logic                    w_rxPush;
  logic [7:0]              w_rxPushData;
  logic                    w_rxPop;
  logic                    w_rxNonEmpty;
  logic [7:0]              w_rxHead;
  logic [RX_DEPTH_LOG:0]   w_rxCount;
  logic                    w_unused;

  // Only bits [17:0] take part in decoding; I/O ports match on the full low
  // 18 bits so aliases like 0x30008 fall into the "other I/O" bucket.
  assign w_ramAddr      = mem_ram_addr[ADDR_WIDTH-1:0];
  assign w_isIo         = (mem_ram_addr[17:16] == 2'b11);
  assign w_ioDataPort   = w_isIo && (mem_ram_addr[15:0] == 16'h0000);
  assign w_ioStatusPort = w_isIo && (mem_ram_addr[15:0] == 16'h0004);
  assign w_busRead      = rdy && !mem_ram_wr;
  assign w_busWrite     = rdy && mem_ram_wr;

  assign w_txHasData  = (w_txCount != '0);
  assign w_rxNonEmpty = (w_rxCount != '0);
  assign w_txPush     = w_busWrite && w_ioDataPort;
  assign w_rxPop      = w_busRead && w_ioDataPort && w_rxNonEmpty;

  // The one-slot margin covers the controller's gap between sampling this
  // flag and actually driving the write.
  assign io_buffer_full = (w_txCount >= TX_FULL_MARK);
  assign tx_data        = w_txHead;

`ifdef RAM_IO_LOOPBACK_EN
  assign w_txPop      = rdy && w_txHasData;
  assign tx_valid     = 1'b0;
  assign w_rxPush     = w_txPop;
  assign w_rxPushData = w_txHead;
  assign w_unused     = ^{mem_ram_addr[XLEN-1:18], tx_ready, rx_valid, rx_data};
`else
  assign w_txPop      = rdy && w_txHasData && tx_ready;
  assign tx_valid     = w_txHasData;
  assign w_rxPush     = rdy && rx_valid;
  assign w_rxPushData = rx_data;
  assign w_unused     = ^mem_ram_addr[XLEN-1:18];
`endif

  ram_io_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_txFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_txPush),
    .i_pop   (w_txPop),
    .i_data  (mem_ram_data),
    .o_head  (w_txHead),
    .o_count (w_txCount)
  );

  ram_io_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rxFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rxPush),
    .i_pop   (w_rxPop),
    .i_data  (w_rxPushData),
    .o_head  (w_rxHead),
    .o_count (w_rxCount)
  );

  // Read data for the I/O window, sampled from state before this edge.
  always_comb begin
    w_ioReadData = 8'h00;
    if (w_ioDataPort) begin
      w_ioReadData = w_rxNonEmpty ? w_rxHead : 8'h00;
    end else if (w_ioStatusPort) begin
      w_ioReadData = {6'b0, w_rxNonEmpty, io_buffer_full};
    end
  end

  // RAM array and its read register carry no reset so they map onto block
  // RAM; the nonblocking read returns the pre-edge byte.
  always_ff @(posedge clk) begin
    if (w_busWrite && !w_isIo) begin
      r_mem[w_ramAddr] <= mem_ram_data;
    end
    if (w_busRead && !w_isIo) begin
      r_ramQ <= r_mem[w_ramAddr];
    end
  end

  // r_selRam chooses the RAM register or the I/O register for ram_data, so
  // clearing r_selRam and r_ioData clears ram_data immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_selRam <= 1'b0;
      r_ioData <= 8'h00;
      r_halt   <= 1'b0;
    end else if (rdy) begin
      if (!mem_ram_wr) begin
        r_selRam <= !w_isIo;
        r_ioData <= w_ioReadData;
      end
      if (mem_ram_wr && w_ioStatusPort) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign ram_data = r_selRam ? r_ramQ : r_ioData;
  assign io_halt  = r_halt;

endmodule

// File: tb/tb_ram_io_responder.sv
`timescale 1ns/1ps
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [31:0] mem_ram_addr = '0;
  logic [7:0]  mem_ram_data = '0;
  logic        mem_ram_wr = 1'b0;
  logic [7:0]  ram_data;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        io_halt;

  int checks = 0;
  int passed = 0;

  // Behavioural model: sparse RAM, byte queues for the FIFOs.
  byte unsigned memModel [int];
  byte unsigned txQ [$];
  byte unsigned rxQ [$];
  byte unsigned expRam;
  bit           expRamKnown;
  bit           expHalt;

  ram_io_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_ram_addr   (mem_ram_addr),
    .mem_ram_data   (mem_ram_data),
    .mem_ram_wr     (mem_ram_wr),
    .ram_data       (ram_data),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .io_halt        (io_halt)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    txQ.delete();
    rxQ.delete();
    expRam      = 8'h00;
    expRamKnown = 1'b1;
    expHalt     = 1'b0;
  endtask

  task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                               input byte unsigned data, input bit txr,
                               input bit rxv, input byte unsigned rxd);
    mem_ram_wr   = wr;
    mem_ram_addr = addr;
    mem_ram_data = data;
    tx_ready     = txr;
    rx_valid     = rxv;
    rx_data      = rxd;
  endtask

  // Advance the model by one bus cycle using the current inputs, then let
  // the DUT take the same edge. Outputs are settled 1ns after the edge.
  task automatic tick();
    logic [17:0] a;
    bit          isIo;
    bit          txPop;
    bit          rxPop;
    bit          txAcc;
    bit          rxAcc;
    int          idx;
    a     = mem_ram_addr[17:0];
    isIo  = (a[17:16] == 2'b11);
    idx   = int'(mem_ram_addr[16:0]);
    if (rdy === 1'b1) begin
      txPop = (txQ.size() != 0) && (tx_ready === 1'b1);
      rxPop = 1'b0;
      txAcc = 1'b0;
      if (mem_ram_wr === 1'b0) begin
        expRamKnown = 1'b1;
        if (!isIo) begin
          if (memModel.exists(idx)) expRam = memModel[idx];
          else expRamKnown = 1'b0;
        end else if (a == 18'h30000) begin
          if (rxQ.size() != 0) begin
            expRam = rxQ[0];
            rxPop  = 1'b1;
          end else begin
            expRam = 8'h00;
          end
        end else if (a == 18'h30004) begin
          expRam = 8'(((rxQ.size() != 0) ? 2 : 0) + ((txQ.size() >= 7) ? 1 : 0));
        end else begin
          expRam = 8'h00;
        end
      end else begin
        expRamKnown = 1'b0;
        if (!isIo) memModel[idx] = mem_ram_data;
        else if (a == 18'h30000) txAcc = (txQ.size() < 8) || txPop;
        else if (a == 18'h30004) expHalt = 1'b1;
      end
      rxAcc = (rx_valid === 1'b1) && ((rxQ.size() < 8) || rxPop);
      if (txPop) void'(txQ.pop_front());
      if (txAcc) txQ.push_back(mem_ram_data);
      if (rxPop) void'(rxQ.pop_front());
      if (rxAcc) rxQ.push_back(rx_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    modelReset();
    checks++; if (ram_data !== 8'h00) $display("[TB] FAIL reset_ram_data: got %h expected 00", ram_data); else passed++;
    checks++; if (io_halt !== 1'b0) $display("[TB] FAIL reset_halt: got %b expected 0", io_halt); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); else passed++;
    checks++; if (io_buffer_full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", io_buffer_full); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram();
    byte unsigned streamVals [4];
    streamVals = '{8'h13, 8'h00, 8'h00, 8'h00};
    applyStimulus(1, 32'h10, 8'hA5, 0, 0, 0); tick();
    applyStimulus(0, 32'h10, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'hA5) $display("[TB] FAIL ram_wr_rd: got %h expected a5", ram_data); else passed++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h100 + 32'(i), streamVals[i], 0, 0, 0); tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 32'h100 + 32'(i), 8'h00, 0, 0, 0); tick();
      checks++; if (ram_data !== streamVals[i]) $display("[TB] FAIL ram_stream%0d: got %h expected %h", i, ram_data, streamVals[i]); else passed++;
    end
    // Upper address bits outside the decode must alias onto the same byte.
    applyStimulus(1, 32'h00F0_0020, 8'h5C, 0, 0, 0); tick();
    applyStimulus(0, 32'h0000_0020, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'h5C) $display("[TB] FAIL ram_alias: got %h expected 5c", ram_data); else passed++;
    applyStimulus(0, 32'h0002_0020, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'h5C) $display("[TB] FAIL ram_alias17: got %h expected 5c", ram_data); else passed++;
  endtask

  task automatic test_tx_fifo();
    byte unsigned got [$];
    int           cnt;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1, 32'h30000, 8'(8'h30 + k - 1), 0, 0, 0); tick();
      cnt = (k > 8) ? 8 : k;
      checks++; if (io_buffer_full !== (cnt >= 7)) $display("[TB] FAIL tx_full_after_%0d: got %b expected %b", k, io_buffer_full, cnt >= 7); else passed++;
      checks++; if (tx_data !== 8'h30) $display("[TB] FAIL tx_head_%0d: got %h expected 30", k, tx_data); else passed++;
    end
    applyStimulus(0, 32'h0, 8'h00, 1, 0, 0);
    for (int c = 0; c < 12; c++) begin
      if (tx_valid === 1'b1) got.push_back(tx_data);
      tick();
      checks++; if (io_buffer_full !== (txQ.size() >= 7)) $display("[TB] FAIL tx_full_drain%0d: got %b expected %b", c, io_buffer_full, txQ.size() >= 7); else passed++;
    end
    checks++; if (got.size() != 8) $display("[TB] FAIL tx_drain_count: got %0d expected 8", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== 8'(8'h30 + i)) $display("[TB] FAIL tx_order%0d: got %h expected %h", i, got[i], 8'(8'h30 + i)); else passed++;
    end
    applyStimulus(0, 32'h0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_rx_fifo();
    applyStimulus(0, 32'h0, 8'h00, 0, 1, 8'h41); tick();
    applyStimulus(0, 32'h30004, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'h02) $display("[TB] FAIL rx_status: got %h expected 02", ram_data); else passed++;
    applyStimulus(0, 32'h30000, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'h41) $display("[TB] FAIL rx_pop: got %h expected 41", ram_data); else passed++;
    tick();
    checks++; if (ram_data !== 8'h00) $display("[TB] FAIL rx_empty: got %h expected 00", ram_data); else passed++;
    // Overfill: bytes beyond eight are dropped.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 32'h0, 8'h00, 0, 1, 8'(8'h50 + i)); tick();
    end
    // Full FIFO with simultaneous pop and push keeps the new byte.
    applyStimulus(0, 32'h30000, 8'h00, 0, 1, 8'h99); tick();
    checks++; if (ram_data !== 8'h50) $display("[TB] FAIL rx_full_pushpop: got %h expected 50", ram_data); else passed++;
    applyStimulus(0, 32'h30000, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (i < 8) begin
        if (ram_data !== 8'(8'h50 + i)) $display("[TB] FAIL rx_drain%0d: got %h expected %h", i, ram_data, 8'(8'h50 + i)); else passed++;
      end else if (i == 8) begin
        if (ram_data !== 8'h99) $display("[TB] FAIL rx_drain%0d: got %h expected 99", i, ram_data); else passed++;
      end else begin
        if (ram_data !== 8'h00) $display("[TB] FAIL rx_drain%0d: got %h expected 00", i, ram_data); else passed++;
      end
    end
    applyStimulus(0, 32'h0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_rdy();
    applyStimulus(1, 32'h30000, 8'h77, 0, 0, 0); tick();
    rdy = 1'b0;
    applyStimulus(1, 32'h10, 8'hEE, 1, 1, 8'h12); tick();
    applyStimulus(1, 32'h30004, 8'h00, 1, 0, 0); tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) $display("[TB] FAIL rdy_tx_hold: got %b/%h expected 1/77", tx_valid, tx_data); else passed++;
    checks++; if (io_halt !== 1'b0) $display("[TB] FAIL rdy_halt_hold: got %b expected 0", io_halt); else passed++;
    rdy = 1'b1;
    applyStimulus(0, 32'h10, 8'h00, 1, 0, 0); tick();
    checks++; if (ram_data !== 8'hA5) $display("[TB] FAIL rdy_ram_hold: got %h expected a5", ram_data); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL rdy_tx_pop: got %b expected 0", tx_valid); else passed++;
    applyStimulus(0, 32'h30004, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'h00) $display("[TB] FAIL rdy_rx_hold: got %h expected 00", ram_data); else passed++;
  endtask

  task automatic test_halt_reset();
    applyStimulus(1, 32'h30004, 8'hFF, 0, 0, 0); tick();
    checks++; if (io_halt !== 1'b1) $display("[TB] FAIL halt_set: got %b expected 1", io_halt); else passed++;
    applyStimulus(0, 32'h0, 8'h00, 0, 0, 0); tick(); tick(); tick();
    checks++; if (io_halt !== 1'b1) $display("[TB] FAIL halt_sticky: got %b expected 1", io_halt); else passed++;
    applyStimulus(1, 32'h30000, 8'h3C, 0, 0, 0); tick();
    applyStimulus(0, 32'h10, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'hA5 || tx_valid !== 1'b1) $display("[TB] FAIL pre_reset: got %h/%b expected a5/1", ram_data, tx_valid); else passed++;
    applyStimulus(0, 32'h0, 8'h00, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checks++; if (io_halt !== 1'b0) $display("[TB] FAIL midreset_halt: got %b expected 0", io_halt); else passed++;
    checks++; if (ram_data !== 8'h00) $display("[TB] FAIL midreset_ram_data: got %h expected 00", ram_data); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL midreset_tx: got %b expected 0", tx_valid); else passed++;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 32'h10, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'hA5) $display("[TB] FAIL ram_survives_reset: got %h expected a5", ram_data); else passed++;
  endtask

  task automatic test_random();
    int          sel;
    int          low;
    bit          wr;
    logic [31:0] addr;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      low = $urandom_range(0, 15);
      wr  = $urandom_range(0, 1) == 1;
      case (sel)
        0, 1, 2: addr = 32'(low);
        3:       addr = 32'h0002_0000 | 32'(low);
        4:       addr = 32'h0100_0000 | 32'(low);
        5:       addr = 32'h0001_0000 | 32'(low);
        6, 7:    addr = 32'h0003_0000;
        8:       addr = 32'h0003_0004;
        default: addr = 32'h0003_0008;
      endcase
      if (sel == 8 && $urandom_range(0, 7) != 0) wr = 1'b0;
      rdy = ($urandom_range(0, 9) != 0);
      applyStimulus(wr, addr, 8'($urandom), $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, 8'($urandom));
      tick();
      checks++; if (io_buffer_full !== (txQ.size() >= 7)) $display("[TB] FAIL rnd_full@%0d: got %b expected %b", n, io_buffer_full, txQ.size() >= 7); else passed++;
      checks++; if (tx_valid !== (txQ.size() != 0)) $display("[TB] FAIL rnd_tx_valid@%0d: got %b expected %b", n, tx_valid, txQ.size() != 0); else passed++;
      if (txQ.size() != 0) begin
        checks++; if (tx_data !== txQ[0]) $display("[TB] FAIL rnd_tx_data@%0d: got %h expected %h", n, tx_data, txQ[0]); else passed++;
      end
      checks++; if (io_halt !== expHalt) $display("[TB] FAIL rnd_halt@%0d: got %b expected %b", n, io_halt, expHalt); else passed++;
      if (expRamKnown) begin
        checks++; if (ram_data !== expRam) $display("[TB] FAIL rnd_ram_data@%0d: got %h expected %h", n, ram_data, expRam); else passed++;
      end
    end
    rdy = 1'b1;
    applyStimulus(0, 32'h0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_loopback();
    applyStimulus(1, 32'h30000, 8'h7E, 0, 0, 0); tick();
    applyStimulus(0, 32'h0, 8'h00, 0, 1, 8'h11); tick(); tick();
    checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL loop_tx_valid: got %b expected 0", tx_valid); else passed++;
    applyStimulus(0, 32'h30000, 8'h00, 0, 0, 0); tick();
    checks++; if (ram_data !== 8'h7E) $display("[TB] FAIL loop_data: got %h expected 7e", ram_data); else passed++;
    tick();
    checks++; if (ram_data !== 8'h00) $display("[TB] FAIL loop_rx_ignored: got %h expected 00", ram_data); else passed++;
  endtask

  initial begin
    test_reset();
`ifdef RAM_IO_LOOPBACK_EN
    test_loopback();
`else
    test_ram();
    test_tx_fifo();
    test_rx_fifo();
    test_rdy();
    test_halt_reset();
    test_random();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Responder end of the byte-wide memory bus driven by `memory_controller`. It owns the unified instruction/data RAM and the memory-mapped I/O window at `0x30000`/`0x30004`. It answers every bus cycle with one-cycle read latency and buffers console output in a TX FIFO, whose near-full state is reported back as `io_buffer_full`. It also buffers console input in an RX FIFO and raises a sticky halt flag for the simulation/FPGA top.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM byte-address width; 2^17 = 128 KiB.
- `TX_DEPTH_LOG`, 3: log2 of the TX FIFO depth (8 entries).
- `RX_DEPTH_LOG`, 3: log2 of the RX FIFO depth (8 entries).

Ports:
- `clk` in 1: single clock; every register updates on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global enable; when low, no state changes.
- `mem_ram_addr` in `XLEN`: byte address from the controller.
- `mem_ram_data` in 8: write byte.
- `mem_ram_wr` in 1: 1 = write, 0 = read.
- `ram_data` out 8: read byte, registered.
- `io_buffer_full` out 1: TX FIFO has ≤1 free slot.
- `tx_valid` out 1: TX FIFO head valid.
- `tx_data` out 8: TX FIFO head byte.
- `tx_ready` in 1: sink accepts the head this cycle.
- `rx_valid` in 1: input byte present; push request.
- `rx_data` in 8: input byte.
- `io_halt` out 1: sticky program-end flag.

## Operation
- Decode:
  - If `mem_ram_addr[17:16] == 2'b11`, the access targets I/O.
  - Otherwise it targets RAM at `mem_ram_addr[ADDR_WIDTH-1:0]`; upper bits are ignored.
- RAM write: the byte is stored at the posedge.
- RAM read: `ram_data` ← RAM[addr] at the posedge.
  - A read of an address written in the same cycle returns the old byte.
- I/O write to `0x30000`: pushes `mem_ram_data` into the TX FIFO.
  - Accepted if count < depth, or if a TX pop occurs in the same cycle.
  - Otherwise the byte is dropped.
- I/O write to `0x30004`: sets `io_halt`; the data byte is ignored.
- I/O read from `0x30000`: `ram_data` ← RX head, and the RX FIFO pops.
  - If the RX FIFO is empty, `ram_data` ← 0 and nothing pops.
- I/O read from `0x30004`: `ram_data` ← `{6'b0, rx_nonempty, io_buffer_full}`. This read has no side effects.
- Any other I/O address:
  - read: `ram_data` ← 0;
  - write: ignored.
- TX drain: `tx_valid` = count ≠ 0 and `tx_data` = head; the FIFO pops when `tx_valid && tx_ready`.
- RX fill: the FIFO pushes when `rx_valid`.
  - If the FIFO is full and no bus pop occurs in the same cycle, the byte is dropped.
  - A push and a pop in the same cycle leave the count unchanged.
- FIFOs:
  - circular buffers with wrap-around pointers and count width `DEPTH_LOG+1`;
  - pointers wrap modulo the depth;
  - the count never exceeds the depth and never goes below 0.
- `io_buffer_full` is combinational from the TX count: count ≥ depth−1. The margin of one covers the controller's one-cycle gap between sampling the flag and driving the write.
- `rdy` low: RAM, both FIFOs, `ram_data` and `io_halt` hold. `tx_valid`/`tx_data` still reflect FIFO contents, but no pop occurs.

## Timing
- Reset (`rst` = 0, asynchronous):
  - `ram_data` = 0, `io_halt` = 0;
  - all FIFO pointers and counts = 0, so `tx_valid` = 0 and `io_buffer_full` = 0.
  - RAM contents are not reset.
- Read latency: address presented in cycle N, byte valid on `ram_data` throughout cycle N+1. This matches the controller sampling `ram_data` one cycle after driving `mem_ram_addr`.
- Consecutive addresses in consecutive cycles stream one byte per cycle, with no bubbles.
- Write: committed at the posedge where it is presented. Visible to a read issued in the next cycle.
- Idle bus (`mem_ram_addr` = 0, `mem_ram_wr` = 0): a harmless RAM read of address 0.
- Reset asserted mid-stream: outputs clear immediately. The bytes already queued in the FIFOs are lost.

## Configuration
- `RAM_IO_LOOPBACK_EN`:
  - Defined:
    - a TX pop pushes the popped byte into the RX FIFO (drop if RX is full);
    - `tx_valid` is held 0 externally;
    - the FIFO drains one byte per cycle regardless of `tx_ready`;
    - `rx_valid`/`rx_data` are ignored.
  - Undefined: behaviour as described above.

## Test plan
- Write `0xA5` to `0x00010`, then read `0x00010` next cycle → `ram_data` = `0xA5` one cycle after the read address.
- Stream reads `0x100`–`0x103` holding bytes `13 00 00 00` → `ram_data` = `0x13, 0x00, 0x00, 0x00` on four consecutive cycles.
- With `tx_ready` = 0, write 7 bytes to `0x30000` → `io_buffer_full` = 1 after the 7th; a 9th write is dropped. Raise `tx_ready` → bytes emerge in order, and `io_buffer_full` drops once count ≤ 6.
- Push `0x41` on `rx`, then read `0x30004` → `0x02`; then read `0x30000` → `0x41`; then read `0x30000` → `0x00`.
- Write any byte to `0x30004` → `io_halt` = 1 and stays 1; assert `rst` = 0 mid-cycle → `io_halt` and `ram_data` clear immediately.
- `RAM_IO_LOOPBACK_EN` build: write `0x7E` to `0x30000`, wait 2 cycles, read `0x30000` → `0x7E`.
